// File: rtl/fifo_enq_arbiter_pkg.sv
// fifo_enq_arbiter_pkg: shared payload-width default, requester-id type and
// the round-robin pointer advance used by the enqueue arbiter.
package fifo_enq_arbiter_pkg;
   localparam int ENTRY_WIDTH_DEF = 32;
   localparam int MAX_REQ = 8;
   typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
   // Pointer moves to the requester after the winner, wrapping at n.
   function automatic req_id_t next_ptr(input req_id_t idx, input int n);
      return (int'(idx) == n - 1) ? '0 : idx + req_id_t'(1);
   endfunction
endpackage

// File: rtl/fifo_enq_arbiter_picker.sv
// rr_priority_picker: wrap-around priority search starting at ptr_i.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot winner,
//        idx_o winner index, any_o high when any request is set.
module rr_priority_picker
   import fifo_enq_arbiter_pkg::*;
#(
   parameter int N = 4,
   localparam int W = $clog2(N)
)(
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
            gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
            idx_o = W'((int'(ptr_i) + k) % N);
            any_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin merge of N_REQ requesters into one registered
// FIFO enqueue slot.
// Ports: clk, rst (sync, active-high), flush (drop held entry),
//        req_valid/req_ready/req_data per requester,
//        out_valid/out_ready/out_data/out_id toward the FIFO.
module fifo_enq_arbiter
   import fifo_enq_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ENTRY_WIDTH = ENTRY_WIDTH_DEF,
   localparam int ID_WIDTH = $clog2(N_REQ)
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [N_REQ-1:0]                    req_valid,
   output logic [N_REQ-1:0]                    req_ready,
   input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]   req_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ENTRY_WIDTH-1:0]              out_data,
   output logic [ID_WIDTH-1:0]                 out_id
);
   logic                   load_en;
   logic                   grant;
   logic                   any;
   logic [N_REQ-1:0]       gnt;
   logic [ID_WIDTH-1:0]    gnt_idx;
   logic                   out_valid_q, out_valid_d;
   logic [ENTRY_WIDTH-1:0] out_data_q, out_data_d;
   logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
   logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
   rr_priority_picker #(.N(N_REQ)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (any)
   );
   always_comb begin
      // Slot accepts a new entry when empty or draining; reset and flush block it.
      load_en     = !rst && !flush && (!out_valid_q || out_ready);
      grant       = load_en && any;
      req_ready   = grant ? gnt : '0;
      out_valid_d = flush ? 1'b0 : grant ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
      out_data_d  = grant ? req_data[gnt_idx] : out_data_q;
      out_id_d    = grant ? gnt_idx : out_id_q;
      rr_ptr_d    = grant ? ID_WIDTH'(next_ptr(req_id_t'(gnt_idx), N_REQ)) : rr_ptr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: vector table, directed corner cases and a randomized
// run into a depth-8 FIFO, all checked against a round-robin reference model.
module tb_fifo_enq_arbiter;
   localparam int N = 4;
   localparam int EW = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic out_ready = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0][EW-1:0] req_data = '0;
   logic [N-1:0] req_ready;
   logic out_valid;
   logic [EW-1:0] out_data;
   logic [1:0] out_id;
   int total = 0;
   int bad = 0;
   // reference model: one slot plus a round-robin start position
   logic m_valid = 1'b0;
   logic [EW-1:0] m_data = '0;
   int m_id = 0;
   int m_ptr = 0;
   logic [N-1:0] exp_ready, obs_ready;
   logic pre_valid, obs_valid;
   logic [EW-1:0] pre_data, obs_data;
   logic [1:0] pre_id, obs_id;
   typedef struct {
      logic r, f;
      logic [N-1:0] v;
      logic o;
      logic [N-1:0] er;
      logic ev;
      int eid;
   } vec_t;
   vec_t tbl[16];
   logic [EW-1:0] pend[N][$];
   logic [EW-1:0] sent[N][$];
   logic [33:0] fifo[$];
   int rcv = 0;
   fifo_enq_arbiter #(.N_REQ(N), .ENTRY_WIDTH(EW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   // One clock: apply inputs, sample comb ready, advance the model, sample regs.
   task automatic drive(input logic r, input logic f, input logic [N-1:0] v, input logic o);
      int g;
      rst = r; flush = f; req_valid = v; out_ready = o;
      #1;
      obs_ready = req_ready; pre_valid = out_valid; pre_data = out_data; pre_id = out_id;
      g = -1;
      if (!r && !f && (!m_valid || o))
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_ready = (g < 0) ? '0 : N'(1 << g);
      if (r) begin
         m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
      end else if (f) begin
         m_valid = 1'b0;
      end else if (g >= 0) begin
         m_valid = 1'b1; m_data = req_data[g]; m_id = g; m_ptr = (g + 1) % N;
      end else if (m_valid && o) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      obs_valid = out_valid; obs_data = out_data; obs_id = out_id;
   endtask
   initial begin
      logic [N-1:0] v;
      logic o;
      logic [33:0] item;
      int id, cyc;
      tbl[0]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[2]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
      tbl[3]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
      tbl[4]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
      tbl[5]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[6]  = '{1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1};
      tbl[7]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 3};
      tbl[8]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
      tbl[9]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1};
      tbl[10] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
      tbl[11] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2};
      tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2};
      tbl[13] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
      tbl[14] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0};
      tbl[15] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      for (int i = 0; i < N; i++) req_data[i] = 32'hC0DE_0000 + i;
      for (int r = 0; r < 16; r++) begin
         drive(tbl[r].r, tbl[r].f, tbl[r].v, tbl[r].o);
         chk($sformatf("row%0d ready", r), obs_ready, tbl[r].er);
         chk($sformatf("row%0d valid", r), obs_valid, tbl[r].ev);
         if (tbl[r].ev || tbl[r].r) begin
            chk($sformatf("row%0d id", r), obs_id, tbl[r].eid);
            chk($sformatf("row%0d data", r), obs_data, tbl[r].r ? 32'h0 : 32'hC0DE_0000 + tbl[r].eid);
         end
      end
      // held entry under backpressure: pointer is 1, requester 2 wins
      req_data[2] = 32'hDEADBEE2;
      drive(1'b0, 1'b0, 4'b0100, 1'b1);
      chk("hold load ready", obs_ready, 4'b0100);
      chk("hold load data", obs_data, 32'hDEADBEE2);
      req_data[2] = 32'h0BAD_0BAD;
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b0, 4'b1111, 1'b0);
         chk($sformatf("stall%0d ready", c), obs_ready, 4'b0000);
         chk($sformatf("stall%0d valid", c), obs_valid, 1'b1);
         chk($sformatf("stall%0d data", c), obs_data, 32'hDEADBEE2);
         chk($sformatf("stall%0d id", c), obs_id, 2'd2);
      end
      // drain and reload in the same cycle
      req_data[1] = 32'h1234_5678;
      drive(1'b0, 1'b0, 4'b0010, 1'b1);
      chk("b2b ready", obs_ready, 4'b0010);
      chk("b2b valid", obs_valid, 1'b1);
      chk("b2b data", obs_data, 32'h1234_5678);
      chk("b2b id", obs_id, 2'd1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1);
      chk("drain valid", obs_valid, 1'b0);
      // randomized traffic into a depth-8 FIFO
      for (int i = 0; i < N; i++)
         for (int s = 0; s < 20; s++) pend[i].push_back({8'(i), 8'(s), 16'($urandom)});
      cyc = 0;
      while ((pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + fifo.size() != 0
              || obs_valid) && cyc < 3000) begin
         cyc++;
         for (int i = 0; i < N; i++) begin
            v[i] = pend[i].size() > 0 && ($urandom % 4 != 0);
            req_data[i] = pend[i].size() > 0 ? pend[i][0] : $urandom;
         end
         o = fifo.size() < 8;
         drive(1'b0, 1'b0, v, o);
         chk("rnd ready", obs_ready, exp_ready);
         chk("rnd valid", obs_valid, m_valid);
         if (m_valid) begin
            chk("rnd data", obs_data, m_data);
            chk("rnd id", obs_id, m_id);
         end
         for (int i = 0; i < N; i++)
            if (obs_ready[i] && pend[i].size() > 0) sent[i].push_back(pend[i].pop_front());
         if (pre_valid && o) fifo.push_back({pre_id, pre_data});
         if (fifo.size() > 0 && ($urandom % 2 == 0)) begin
            item = fifo.pop_front();
            id = int'(item[33:32]);
            rcv++;
            if (sent[id].size() == 0) begin
               total++; bad++;
               $display("FAIL rnd dup: id %0d data %h with nothing outstanding", id, item[31:0]);
            end else begin
               chk($sformatf("rnd order id%0d", id), item[31:0], sent[id].pop_front());
            end
         end
      end
      chk("rnd drained", cyc < 3000, 1'b1);
      chk("rnd received", rcv, 80);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_enq_arbiter.md
FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one FIFO enqueue port; legal values 2..8.
REQ-002 SHALL have parameter ENTRY_WIDTH, default 32: payload width, equal to the FIFO ENTRY_WIDTH.
REQ-003 SHALL have derived localparam ID_WIDTH = $clog2(N_REQ).
REQ-004 SHALL have clk  input  1: single clock; all state updates on posedge.
REQ-005 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have flush  input  1: synchronous discard of the held output entry.
REQ-007 SHALL have req_valid  input  N_REQ: per-requester valid.
REQ-008 SHALL have req_ready  output  N_REQ: per-requester ready; one-hot or zero.
REQ-009 SHALL have req_data  input  N_REQ x ENTRY_WIDTH: per-requester payload.
REQ-010 SHALL have out_valid  output  1: drives FIFO enq_valid.
REQ-011 SHALL have out_ready  input  1: driven by FIFO enq_ready.
REQ-012 SHALL have out_data  output  ENTRY_WIDTH: drives FIFO enq_data.
REQ-013 SHALL have out_id  output  ID_WIDTH: index of the requester that sourced out_data.

Function
REQ-014 SHALL hold one registered output entry (out_valid/out_data/out_id); outputs are register outputs only.
REQ-015 SHALL define load_en = !flush && (!out_valid || out_ready): the slot is free or drains this cycle.
REQ-016 SHALL grant, when load_en, the first i with req_valid[i] searching from rr_ptr upward with wrap-around modulo N_REQ.
REQ-017 SHALL drive req_ready[i]=1 only for the granted i; req_ready is combinational from req_valid, rr_ptr, out_valid, out_ready, flush.
REQ-018 SHALL, on a grant to i, load out_data<=req_data[i], out_id<=i, out_valid<=1 on the next posedge: latency 1 cycle from request to out_valid.
REQ-019 SHALL, on a grant to i, update rr_ptr <= (i+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-020 SHALL, when out_valid && out_ready && no grant, clear out_valid on the next posedge.
REQ-021 SHALL keep out_data/out_id stable while out_valid && !out_ready.
REQ-022 SHALL support full throughput: a drain and a new grant in the same cycle yield back-to-back out_valid.
REQ-023 SHALL, when flush=1, clear out_valid next posedge, drive req_ready=0, and leave rr_ptr unchanged.
REQ-024 SHALL never drop or duplicate a payload: each req handshake yields exactly one out handshake unless flushed.
REQ-025 SHALL ignore req_data of non-granted requesters.

Reset
REQ-026 SHALL, with rst=1 at posedge, set out_valid=0, out_data=0, out_id=0, rr_ptr=0.
REQ-027 SHALL drive req_ready=0 during any cycle rst=1.
REQ-028 SHALL give rst priority over flush and grants; reset mid-transfer discards the held entry.

Structure
REQ-029 SHALL import a shared package holding ENTRY_WIDTH default and the requester-id typedef.
REQ-030 SHALL implement the wrap-around priority search as sub-module rr_priority_picker (inputs req vector, ptr; outputs one-hot grant, grant index, any).

Verification
REQ-031 SHALL cover: reset, all req_valid=1 -> cycle after reset release out_id=0, then 1,2,3,0 with out_ready=1.
REQ-032 SHALL cover: req_valid=4'b1010, rr_ptr=2 -> grant id 3, rr_ptr=0; next grant id 1.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with out_valid=1, data 32'hDEADBEE2 -> out_data stable, req_ready=0, no grants.
REQ-034 SHALL cover: out_valid=1, out_ready=1, req_valid[1]=1 same cycle -> req_ready[1]=1, out_valid stays 1 with new data.
REQ-035 SHALL cover: flush=1 with out_valid=1, rr_ptr=2 -> out_valid=0 next cycle, req_ready=0, rr_ptr=2.
REQ-036 SHALL cover: connected to fifo N_ENTRIES=8, 4 requesters x 20 random payloads -> dequeued stream matches per-requester order, none lost.
